// File: rtl/term_ser_pkg.sv
// rtl/term_ser_pkg.sv - shared types and constants for the term bus serializer
//
// Contents:
//   ser_state_t    : serializer FSM states (IDLE, SHIFT, PARITY)
//   TERM_BUS_WIDTH : default parallel word width of the term bus
//   cnt_width()    : bit-counter width for a given word width (at least 1)
package term_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int TERM_BUS_WIDTH = 32;

    // Counter must be able to hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/term_ser_bitcnt.sv
// rtl/term_ser_bitcnt.sv - loadable down-counter with zero flag for the serializer
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (count clears to 0)
//   load     : load load_val this edge (has priority over en)
//   load_val : value to load
//   en       : decrement by one; saturates at zero
//   zero     : count is zero
module term_ser_bitcnt #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/term_bus_serializer.sv
// rtl/term_bus_serializer.sv - parallel term bus word to framed bit-serial line
//
// Optional feature: define TERM_SER_PARITY_EN to append an even-parity bit
// after the data bits (frame length WIDTH+1 instead of WIDTH).
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_data   : parallel word, sampled on in_valid && in_ready
//   in_valid  : upstream word available
//   in_ready  : word can be accepted this cycle
//   ser_en    : downstream advance strobe; 0 holds the current bit
//   ser_out   : current serial bit
//   ser_frame : ser_out carries a data (or parity) bit
//   ser_last  : ser_out carries the final bit of the word
module term_bus_serializer
    import term_ser_pkg::*;
#(
    parameter int WIDTH     = TERM_BUS_WIDTH,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             ser_last
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_t       state, next_state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             head;
    logic             cnt_zero;
    logic             ready_raw;
    logic             load;
    logic             advance;

    // Zeros are shifted in behind the data so the head reads 0 once a word
    // has fully drained, keeping ser_out low in IDLE without extra muxing.
    assign head    = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
    assign shifted = (LSB_FIRST != 0) ? {1'b0, shreg[WIDTH-1:1]}
                                      : {shreg[WIDTH-2:0], 1'b0};

    always_comb begin
        next_state = state;
        ready_raw  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    advance = 1'b1;
                    if (cnt_zero) begin
`ifdef TERM_SER_PARITY_EN
                        next_state = PARITY;
`else
                        // Final data bit leaving: accept the next word on the
                        // same edge for gapless streaming.
                        ready_raw = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
`endif
                    end
                end
            end
            PARITY: begin
                if (ser_en) begin
                    ready_raw = 1'b1;
                    if (in_valid) begin
                        load       = 1'b1;
                        next_state = SHIFT;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Held low while reset is asserted; ready depends only on state, counter
    // and ser_en, never on in_valid.
    assign in_ready = rst_n && ready_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= next_state;
            if (load) begin
                shreg <= in_data;
            end else if (advance) begin
                shreg <= shifted;
            end
        end
    end

    term_ser_bitcnt #(
        .CW (CW)
    ) u_bitcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (LAST_IDX),
        .en       (advance && !load),
        .zero     (cnt_zero)
    );

`ifdef TERM_SER_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= ^in_data;
        end
    end

    assign ser_out  = (state == PARITY) ? par_bit : head;
    assign ser_last = (state == PARITY);
`else
    assign ser_out  = head;
    assign ser_last = (state == SHIFT) && cnt_zero;
`endif

    assign ser_frame = (state != IDLE);

endmodule

// File: tb/tb_term_bus_serializer.sv
// tb/tb_term_bus_serializer.sv - directed self-checking bench for term_bus_serializer
module tb_term_bus_serializer;

    localparam int W = 32;
`ifdef TERM_SER_PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_en;
    logic         ser_out;
    logic         ser_frame;
    logic         ser_last;

    int tests;
    int fails;

    term_bus_serializer #(
        .WIDTH     (W),
        .LSB_FIRST (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_en    (ser_en),
        .ser_out   (ser_out),
        .ser_frame (ser_frame),
        .ser_last  (ser_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bit i of a frame (MSB first, optional trailing even parity).
    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[W-1-i];
        return ^w;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_frame"}, 64'(ser_frame), 64'd0);
        chk({tag, "_out"},   64'(ser_out),   64'd0);
        chk({tag, "_last"},  64'(ser_last),  64'd0);
    endtask

    // Send one word with ser_en held high and check every frame cycle.
    task automatic send_word(input string tag, input logic [W-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        ser_en   = 1'b1;
        #1;
        chk({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        for (int i = 0; i < NBITS; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 64'(ser_out), 64'(exp_bit(w, i)));
            chk($sformatf("%s_frame%0d", tag, i), 64'(ser_frame), 64'd1);
            chk($sformatf("%s_last%0d", tag, i), 64'(ser_last), 64'(i == NBITS - 1));
            chk($sformatf("%s_ready%0d", tag, i), 64'(in_ready), 64'(i == NBITS - 1));
            @(posedge clk);
            @(negedge clk);
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        logic [W-1:0] wc;
        int k;
        int cyc;
        logic en;

        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        ser_en   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        check_idle("rst");
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ready%0d", i), 64'(in_ready), 64'd1);
            check_idle($sformatf("idle%0d", i));
        end

        // Single word, edge bits set
        send_word("w80000001", 32'h8000_0001);

        // Back-to-back words with in_valid held
        wa = 32'hA5A5_A5A5;
        wb = 32'h0000_FFFF;
        in_data  = wa;
        in_valid = 1'b1;
        ser_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = wb;
        for (int i = 0; i < 2 * NBITS; i++) begin
            if (i == NBITS) in_valid = 1'b0;
            chk($sformatf("b2b_bit%0d", i), 64'(ser_out),
                64'(exp_bit((i < NBITS) ? wa : wb, i % NBITS)));
            chk($sformatf("b2b_frame%0d", i), 64'(ser_frame), 64'd1);
            chk($sformatf("b2b_last%0d", i), 64'(ser_last), 64'((i % NBITS) == NBITS - 1));
            @(posedge clk);
            @(negedge clk);
        end
        check_idle("b2b_end");

        // ser_en pattern 1,0,0,1 during a word
        wc = 32'h1234_5678;
        in_data  = wc;
        in_valid = 1'b1;
        ser_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < NBITS && cyc < 200) begin
            chk($sformatf("en_bit%0d_c%0d", k, cyc), 64'(ser_out), 64'(exp_bit(wc, k)));
            chk($sformatf("en_frame_c%0d", cyc), 64'(ser_frame), 64'd1);
            chk($sformatf("en_last_c%0d", cyc), 64'(ser_last), 64'(k == NBITS - 1));
            en = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            ser_en = en;
            #1;
            chk($sformatf("en_ready_c%0d", cyc), 64'(in_ready), 64'((k == NBITS - 1) && en));
            @(posedge clk);
            @(negedge clk);
            if (en) k++;
            cyc++;
        end
        chk("en_bound", 64'(k), 64'(NBITS));
        check_idle("en_end");

        // Reset asserted mid-word
        in_data  = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        ser_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rstmid_bit%0d", i), 64'(ser_out), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        chk("rstmid_frame_before", 64'(ser_frame), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 64'(in_ready), 64'd0);
        check_idle("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmid_rel_ready", 64'(in_ready), 64'd1);
        check_idle("rstmid_rel");
        @(negedge clk);
        send_word("w00000003", 32'h0000_0003);

`ifdef TERM_SER_PARITY_EN
        send_word("par7", 32'h0000_0007);
        send_word("par3", 32'h0000_0003);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
